// File: rtl/fix_msg_composer.sv
// rtl/fix_msg_composer.sv - FIX 4.3 session message serializer with BodyLength and CheckSum generation
module fix_msg_composer #(
   parameter logic [7:0] SOH      = 8'h01,
   parameter int         ID_BYTES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [3:0]            type_i,
   input  logic [8*ID_BYTES-1:0] seqnum_i,
   input  logic [8*ID_BYTES-1:0] sender_i,
   input  logic [8*ID_BYTES-1:0] target_i,
   input  logic [167:0]          sendtime_i,
   input  logic [23:0]           hbint_i,
   input  logic [8*ID_BYTES-1:0] seq_a_i,
   input  logic [8*ID_BYTES-1:0] seq_b_i,
   output logic [7:0]            data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  sop_o,
   output logic                  eop_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int IW = 8*ID_BYTES;
   localparam int VW = (IW > 168) ? IW : 168;

   localparam logic [3:0] T_HEARTBEAT  = 4'd0;
   localparam logic [3:0] T_LOGON      = 4'd1;
   localparam logic [3:0] T_LOGOUT     = 4'd2;
   localparam logic [3:0] T_RESEND_REQ = 4'd3;
   localparam logic [3:0] T_RESET      = 4'd4;
   localparam logic [3:0] T_GAP_FILL   = 4'd5;

   localparam logic [95:0] HDR_STR = {"8=FIX.4.3", SOH, "9="};

   typedef enum logic [2:0] {IDLE, HDR, BLEN, BODY, CSUM, DONE} state_t;
   state_t state, state_nxt;

   logic [3:0]    type_r;
   logic [IW-1:0] seqnum_r, sender_r, target_r, seq_a_r, seq_b_r;
   logic [167:0]  sendtime_r;
   logic [23:0]   hbint_r;

   logic [7:0]  cnt, cnt_nxt;
   logic [2:0]  fld, fld_nxt;
   logic [7:0]  csum;
   logic        err_r;
   logic        accept, fire, supported;
   logic [7:0]  mtype;
   int          nf, blen, c, plen, vlen, flen;
   logic [31:0] pfx;
   logic [VW-1:0] val;
   logic [7:0]  body_byte;
   logic [31:0] blen_str;
   logic [55:0] trl_str;

   function automatic logic [7:0] dec_digit(input int v, input int place);
      return 8'(48 + (v / place) % 10);
   endfunction

   assign accept      = req_valid_i && (state == IDLE);
   assign fire        = valid_o && ready_i;
   assign req_ready_o = (state == IDLE);
   assign err_o       = err_r;
   assign c           = int'(cnt);

   always_comb begin
      supported = 1'b0;
      case (type_i)
         T_HEARTBEAT, T_LOGON, T_LOGOUT, T_RESEND_REQ, T_RESET, T_GAP_FILL: supported = 1'b1;
         default: supported = 1'b0;
      endcase
   end

   // Per-type constants: MsgType char, field count and the fixed BodyLength
   always_comb begin
      mtype = "0";
      nf    = 5;
      blen  = 42 + 3*ID_BYTES;
      case (type_r)
         T_LOGOUT:     mtype = "5";
         T_LOGON:      begin mtype = "A"; nf = 7; blen = 55 + 3*ID_BYTES; end
         T_RESEND_REQ: begin mtype = "2"; nf = 7; blen = 49 + 5*ID_BYTES; end
         T_RESET:      begin mtype = "4"; nf = 6; blen = 46 + 4*ID_BYTES; end
         T_GAP_FILL:   begin mtype = "4"; nf = 7; blen = 52 + 4*ID_BYTES; end
         default:      mtype = "0";
      endcase
   end

   // Field sequencer table: tag prefix (right-aligned) and value source per field index
   always_comb begin
      pfx  = '0;
      plen = 3;
      val  = '0;
      vlen = ID_BYTES;
      case (fld)
         3'd0: begin pfx = 32'("35="); val = VW'(mtype); vlen = 1; end
         3'd1: begin pfx = 32'("34="); val = VW'(seqnum_r); end
         3'd2: begin pfx = 32'("49="); val = VW'(sender_r); end
         3'd3: begin pfx = 32'("56="); val = VW'(target_r); end
         3'd4: begin pfx = 32'("52="); val = VW'(sendtime_r); vlen = 21; end
         3'd5: begin
            case (type_r)
               T_LOGON:      begin pfx = 32'("98="); val = VW'("0"); vlen = 1; end
               T_RESEND_REQ: begin pfx = 32'("7="); plen = 2; val = VW'(seq_a_r); end
               T_GAP_FILL:   begin pfx = 32'("123="); plen = 4; val = VW'("Y"); vlen = 1; end
               default:      begin pfx = 32'("36="); val = VW'(seq_a_r); end
            endcase
         end
         default: begin
            case (type_r)
               T_LOGON:      begin pfx = 32'("108="); plen = 4; val = VW'(hbint_r); vlen = 3; end
               T_RESEND_REQ: begin pfx = 32'("16="); val = VW'(seq_b_r); end
               default:      begin pfx = 32'("36="); val = VW'(seq_a_r); end
            endcase
         end
      endcase
   end

   always_comb begin
      flen = plen + vlen + 1;
      if (c < plen)
         body_byte = 8'(pfx >> (8*(plen - 1 - c)));
      else if (c < plen + vlen)
         body_byte = 8'(val >> (8*(vlen - 1 - (c - plen))));
      else
         body_byte = SOH;
   end

   // Checksum register is final by the time CSUM is entered; "10=" gives the digits slack
   always_comb begin
      blen_str = {dec_digit(blen, 100), dec_digit(blen, 10), dec_digit(blen, 1), SOH};
      trl_str  = {"10=", dec_digit(int'(csum), 100), dec_digit(int'(csum), 10),
                  dec_digit(int'(csum), 1), SOH};
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fld_nxt   = fld;
      valid_o   = 1'b0;
      data_o    = '0;
      sop_o     = 1'b0;
      eop_o     = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (accept && supported) begin
               state_nxt = HDR;
               cnt_nxt   = '0;
               fld_nxt   = '0;
            end
         end
         HDR: begin
            valid_o = 1'b1;
            sop_o   = (c == 0);
            data_o  = 8'(HDR_STR >> (8*(11 - c)));
            if (ready_i) begin
               if (c == 11) begin state_nxt = BLEN; cnt_nxt = '0; end
               else cnt_nxt = cnt + 8'd1;
            end
         end
         BLEN: begin
            valid_o = 1'b1;
            data_o  = 8'(blen_str >> (8*(3 - c)));
            if (ready_i) begin
               if (c == 3) begin state_nxt = BODY; cnt_nxt = '0; fld_nxt = '0; end
               else cnt_nxt = cnt + 8'd1;
            end
         end
         BODY: begin
            valid_o = 1'b1;
            data_o  = body_byte;
            if (ready_i) begin
               if (c == flen - 1) begin
                  cnt_nxt = '0;
                  if (int'(fld) == nf - 1) state_nxt = CSUM;
                  else fld_nxt = fld + 3'd1;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         CSUM: begin
            valid_o = 1'b1;
            eop_o   = (c == 6);
            data_o  = 8'(trl_str >> (8*(6 - c)));
            if (ready_i) begin
               if (c == 6) begin state_nxt = DONE; cnt_nxt = '0; end
               else cnt_nxt = cnt + 8'd1;
            end
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         fld   <= '0;
         csum  <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         fld   <= fld_nxt;
         err_r <= accept && !supported;
         if (accept)
            csum <= '0;
         else if (fire && (state == HDR || state == BLEN || state == BODY))
            csum <= csum + data_o;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         type_r     <= type_i;
         seqnum_r   <= seqnum_i;
         sender_r   <= sender_i;
         target_r   <= target_i;
         sendtime_r <= sendtime_i;
         hbint_r    <= hbint_i;
         seq_a_r    <= seq_a_i;
         seq_b_r    <= seq_b_i;
      end
   end

endmodule
